// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_sequencer
//  Description : Program-side instruction source for the CPU datapath.
//                A small program store is written through a load port while
//                idle. On start, instructions are fetched in address order
//                and offered over a valid/ready handshake. A fixed number of
//                idle cycles is forced after every accepted issue, and a
//                one-cycle done pulse marks the end of the run.
//                Instruction word: [11:9] opcode, [8:6] dest, [5:3] src1,
//                [2:0] src2.
//  Ports       : clk, rst          clock / synchronous active-high reset
//                load_en/addr/data program-store write port (IDLE only)
//                start, prog_len   run request and instruction count
//                instr_out/valid   offered instruction
//                instr_ready       consumer acceptance
//                busy, done, pc    status: running, completion pulse, next addr
//  Revision    : 1.0  initial release
// ============================================================================
module instr_sequencer #(
    parameter int INSTR_W = 12,
    parameter int ADDR_W  = 4,
    parameter int GAP     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               start,
    input  logic [ADDR_W:0]    prog_len,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  pc
);

    localparam int DEPTH = 2 ** ADDR_W;
    // The gap counter keeps at least one bit so GAP == 0 still elaborates.
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ISSUE   = 3'd2,
        S_GAPWAIT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   mem_q [DEPTH];
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [ADDR_W:0]      len_q, len_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [ADDR_W:0]      count_inc;
    logic                 mem_we;

    assign count_inc = count_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            pc_q    <= '0;
            len_q   <= '0;
            count_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            count_q <= count_d;
            gap_q   <= gap_d;
        end
    end

    // Program store survives reset; writes are simply blocked while in reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        len_d   = len_q;
        count_d = count_q;
        gap_d   = gap_q;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A write on the start edge lands before the first FETCH reads it.
                mem_we = load_en;
                if (start) begin
                    len_d   = prog_len;
                    pc_d    = '0;
                    count_d = '0;
                    state_d = (prog_len == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                instr_d = mem_q[pc_q];
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    count_d = count_inc;
                    pc_d    = pc_q + 1'b1;
                    if (count_inc == len_q) begin
                        state_d = S_DONE;
                    end else if (GAP > 0) begin
                        gap_d   = GAP_LOAD;
                        state_d = S_GAPWAIT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_GAPWAIT: begin
                gap_d = gap_q - 1'b1;
                if (gap_q <= GAP_ONE) begin
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign instr_out   = instr_q;
    assign instr_valid = (state_q == S_ISSUE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign pc          = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_sequencer
//  Description : Self-checking bench for instr_sequencer. Two instances are
//                driven: A (ADDR_W=4, GAP=2) and B (ADDR_W=2, GAP=0). A
//                cycle-level reference model predicts, from the handshake
//                rules, when each word is offered, which word it is, the pc,
//                busy and the done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int IW  = 12;
    localparam int AW  = 4;
    localparam int GA  = 2;
    localparam int AWB = 2;
    localparam int GB  = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          a_load_en, a_start, a_instr_valid, a_instr_ready, a_busy, a_done;
    logic [AW-1:0] a_load_addr, a_pc;
    logic [IW-1:0] a_load_data, a_instr_out;
    logic [AW:0]   a_prog_len;

    logic           b_load_en, b_start, b_instr_valid, b_instr_ready, b_busy, b_done;
    logic [AWB-1:0] b_load_addr, b_pc;
    logic [IW-1:0]  b_load_data, b_instr_out;
    logic [AWB:0]   b_prog_len;

    logic [IW-1:0] model_a [2**AW];
    logic [IW-1:0] model_b [2**AWB];

    int checks = 0;
    int errors = 0;

    instr_sequencer #(.INSTR_W(IW), .ADDR_W(AW), .GAP(GA)) u_dut_a (
        .clk(clk), .rst(rst),
        .load_en(a_load_en), .load_addr(a_load_addr), .load_data(a_load_data),
        .start(a_start), .prog_len(a_prog_len),
        .instr_out(a_instr_out), .instr_valid(a_instr_valid), .instr_ready(a_instr_ready),
        .busy(a_busy), .done(a_done), .pc(a_pc)
    );

    instr_sequencer #(.INSTR_W(IW), .ADDR_W(AWB), .GAP(GB)) u_dut_b (
        .clk(clk), .rst(rst),
        .load_en(b_load_en), .load_addr(b_load_addr), .load_data(b_load_data),
        .start(b_start), .prog_len(b_prog_len),
        .instr_out(b_instr_out), .instr_valid(b_instr_valid), .instr_ready(b_instr_ready),
        .busy(b_busy), .done(b_done), .pc(b_pc)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [IW-1:0] mword(input bit sel, input int i);
        return sel ? model_b[i % (2**AWB)] : model_a[i % (2**AW)];
    endfunction

    task automatic load(input bit sel, input int addr, input logic [IW-1:0] d);
        if (sel) begin
            b_load_en = 1'b1; b_load_addr = AWB'(addr); b_load_data = d; model_b[addr] = d;
        end else begin
            a_load_en = 1'b1; a_load_addr = AW'(addr); a_load_data = d; model_a[addr] = d;
        end
        tick();
        a_load_en = 1'b0;
        b_load_en = 1'b0;
    endtask

    // Starts a run and checks every cycle until one cycle after done.
    // hold: ready forced low for the first 'hold' offered cycles.
    // scribble: drive random store writes throughout the run (must be ignored).
    task automatic run_seq(input bit sel, input int len, input int rdy_pct, input int hold,
                           input bit scribble, input string name);
        int depth    = sel ? 2**AWB : 2**AW;
        int gap      = sel ? GB : GA;
        int idx      = 0;
        int c        = 1;
        int next_v   = 2;
        int done_cyc = (len == 0) ? 1 : 1_000_000;
        int held     = 0;
        bit rdy, exp_v, exp_d, exp_b;
        logic [AW-1:0] exp_pc, opc;
        logic [IW-1:0] oout;
        logic ov, od, ob;
        if (sel) begin
            b_prog_len = len[AWB:0]; b_start = 1'b1;
        end else begin
            a_prog_len = len[AW:0]; a_start = 1'b1;
        end
        tick();
        a_start = 1'b0; b_start = 1'b0;
        a_load_en = 1'b0; b_load_en = 1'b0;
        while (c <= done_cyc + 1) begin
            if (c > 600) begin
                checks++; errors++;
                $display("FAIL %s timeout: no done after %0d cycles, issued %0d of %0d", name, c, idx, len);
                break;
            end
            ov   = sel ? b_instr_valid : a_instr_valid;
            od   = sel ? b_done : a_done;
            ob   = sel ? b_busy : a_busy;
            opc  = sel ? AW'(b_pc) : a_pc;
            oout = sel ? b_instr_out : a_instr_out;
            exp_v  = (idx < len) && (c >= next_v);
            exp_d  = (c == done_cyc);
            exp_b  = (c <= done_cyc);
            exp_pc = AW'(idx % depth);
            checks++;
            if ({ov, od, ob, opc} !== {exp_v, exp_d, exp_b, exp_pc}) begin
                errors++;
                $display("FAIL %s cyc%0d valid/done/busy/pc got %b/%b/%b/%h exp %b/%b/%b/%h",
                         name, c, ov, od, ob, opc, exp_v, exp_d, exp_b, exp_pc);
            end
            if (exp_v) begin
                checks++;
                if (oout !== mword(sel, idx)) begin
                    errors++;
                    $display("FAIL %s cyc%0d instr_out got %h exp %h (index %0d)",
                             name, c, oout, mword(sel, idx), idx);
                end
            end
            if (c <= done_cyc) begin
                if (exp_v && held < hold) begin
                    rdy = 1'b0; held++;
                end else begin
                    rdy = ($urandom_range(0, 99) < rdy_pct);
                end
                if (exp_v && rdy) begin
                    idx++;
                    if (idx == len) done_cyc = c + 1;
                    else            next_v   = c + gap + 2;
                end
            end else begin
                rdy = 1'b0;
            end
            if (sel) b_instr_ready = rdy; else a_instr_ready = rdy;
            if (scribble && c <= done_cyc) begin
                if (sel) begin
                    b_load_en = 1'b1; b_load_addr = AWB'($urandom); b_load_data = IW'($urandom);
                end else begin
                    a_load_en = 1'b1; a_load_addr = AW'($urandom); a_load_data = IW'($urandom);
                end
            end else begin
                a_load_en = 1'b0; b_load_en = 1'b0;
            end
            tick();
            c++;
        end
        a_load_en = 1'b0; b_load_en = 1'b0;
        a_instr_ready = 1'b0; b_instr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({a_instr_out, a_instr_valid, a_busy, a_done, a_pc} !== '0) begin
            errors++;
            $display("FAIL reset_a out/valid/busy/done/pc got %h/%b/%b/%b/%h exp all zero",
                     a_instr_out, a_instr_valid, a_busy, a_done, a_pc);
        end
        checks++;
        if ({b_instr_out, b_instr_valid, b_busy, b_done, b_pc} !== '0) begin
            errors++;
            $display("FAIL reset_b out/valid/busy/done/pc got %h/%b/%b/%b/%h exp all zero",
                     b_instr_out, b_instr_valid, b_busy, b_done, b_pc);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        load(0, 0, 12'h2C8);
        load(0, 1, 12'h30A);
        load(0, 2, 12'h04B);
        run_seq(0, 3, 100, 0, 0, "basic_gap2");
    endtask

    task automatic test_stall();
        run_seq(0, 3, 100, 5, 0, "stall5");
        run_seq(0, 3, 40, 2, 0, "stall_random");
    endtask

    task automatic test_len0();
        run_seq(0, 0, 100, 0, 0, "len0");
    endtask

    task automatic test_load_start();
        logic [IW-1:0] d;
        d = IW'($urandom);
        a_load_en = 1'b1; a_load_addr = '0; a_load_data = d; model_a[0] = d;
        run_seq(0, 2, 100, 0, 0, "load_with_start");
    endtask

    task automatic test_reset_midrun();
        int seen = 0;
        int n = 0;
        bit stray = 1'b0;
        a_instr_ready = 1'b1;
        a_prog_len = 5'd3;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        while (seen < 2 && n < 20) begin
            if (a_instr_valid) seen++;
            if (seen < 2) begin
                tick();
                n++;
            end
        end
        checks++;
        if (seen != 2) begin
            errors++;
            $display("FAIL midrun_wait got %0d valid cycles exp 2 within 20 cycles", seen);
        end
        rst = 1'b1;
        a_instr_ready = 1'b0;
        tick();
        checks++;
        if ({a_instr_out, a_instr_valid, a_busy, a_done, a_pc} !== '0) begin
            errors++;
            $display("FAIL midrun_reset out/valid/busy/done/pc got %h/%b/%b/%b/%h exp all zero",
                     a_instr_out, a_instr_valid, a_busy, a_done, a_pc);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (a_done || a_busy || a_instr_valid) stray = 1'b1;
            tick();
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL midrun_after activity after abort got 1 exp 0");
        end
        run_seq(0, 3, 100, 0, 0, "rerun_after_reset");
    endtask

    task automatic test_gap0();
        load(1, 0, 12'hA5C);
        load(1, 1, 12'h13F);
        run_seq(1, 2, 100, 0, 0, "gap0_len2");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) load(1, i, IW'($urandom));
        run_seq(1, 4, 100, 0, 1, "wrap_scribble");
        run_seq(1, 4, 60, 0, 0, "wrap_rerun");
        run_seq(0, 16, 100, 0, 0, "wrap_full_a");
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) load(0, i, IW'($urandom));
            run_seq(0, int'($urandom_range(1, 16)), 50, 0, r[0], "random_a");
            run_seq(1, int'($urandom_range(1, 4)), 50, 0, 1'b0, "random_b");
        end
    endtask

    initial begin
        rst = 1'b1;
        a_load_en = 1'b0; a_load_addr = '0; a_load_data = '0; a_start = 1'b0;
        a_prog_len = '0; a_instr_ready = 1'b0;
        b_load_en = 1'b0; b_load_addr = '0; b_load_data = '0; b_start = 1'b0;
        b_prog_len = '0; b_instr_ready = 1'b0;
        for (int i = 0; i < 2**AW; i++) model_a[i] = '0;
        for (int i = 0; i < 2**AWB; i++) model_b[i] = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_len0();
        test_load_start();
        test_reset_midrun();
        test_gap0();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
